execute_mdu: RTL
================

Name: execute_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage.
- Consumes the Execute pipeline register outputs: EXRD1 as operand A, EXRD2 as operand B, and an op code decoded from EXIR.
- Holds the architectural HI/LO registers.
- Exposes busy and start to the hazard unit so that later MD-class instructions stall until the operation finishes.
- Provides mfhi/mflo read data to the Execute-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled only at posedge clk.
- start  input  1  issue pulse for mult/multu/div/divu; ignored unless the stage is valid and not stalled upstream.
- op  input  4  MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; other codes are treated as none.
- A  input  32  operand rs (forwarded EXRD1).
- B  input  32  operand rt (forwarded EXRD2).
- busy  output  1  high while an operation is in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- MDOut  output  32  HI when op=mfhi, LO when op=mflo, else 0; combinational.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset dominates every other input. Reset mid-operation aborts the operation and leaves HI/LO at 0.
- States: IDLE and RUN, implied by busy.
- IDLE, start=1 with op in {1,2,3,4}, sampled at edge E0:
  - The result is computed from A and B at E0 and latched into pending HI/LO.
  - Counter is loaded with N-1 (N = MULT_CYCLES or DIV_CYCLES).
  - busy=1 from E0 onward.
- RUN: counter decrements each edge. At the edge where counter==0, pending values are written to HI/LO and busy falls at that same edge. busy is therefore high for exactly N cycles, and new HI/LO are visible in the cycle after the last busy cycle.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64; same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - B==0 for div/divu: the op still takes DIV_CYCLES, and HI/LO keep their prior values.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: HI (or LO) <= A at the next edge; busy is unaffected. start is not required for these ops.
- start while busy: ignored; there is no queueing. The hazard unit must stall on (busy | start) & MD-class op in Execute.
- mthi/mtlo while busy: ignored. The hazard unit prevents this case.
- mfhi/mflo: MDOut reflects the current HI/LO register value. While busy it shows the old value; the stall makes this harmless.
- start with op not in {1..4}: no effect.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- With the macro defined:
  - An extra input port cancel (1 bit) is added.
  - cancel=1 at an edge while busy aborts the operation: busy goes to 0 at that edge, HI/LO keep their pre-start values, pending results are discarded.
  - cancel together with start in IDLE suppresses the start.
  - cancel together with mthi/mtlo suppresses the write.
  - This supports precise exceptions in a later stage.
- Without the macro: no cancel port; operations always run to completion.

Decomposition:
- Shared package/include holds:
  - the MD op code constants (MD_NONE..MD_MTLO, 4 bits);
  - default cycle counts.
- The same op constants are used by the decode controller and the hazard unit.
- One sub-module is natural: mdu_arith, a combinational 64-bit product/quotient/remainder generator covering signed/unsigned and the divide-by-zero flag. The top level owns the counter, pending registers, HI/LO, and busy.

Test Plan:
- Reset then mult A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then mflo/mfhi -> next cycle MDOut=0x12345678 for mfhi. Start with a different op asserted during busy -> ignored, counter unaffected.
- Reset asserted in the 3rd busy cycle of a div -> next cycle busy=0, HI=LO=0, no later write.
- MDU_CANCEL_EN: HI=5, LO=6, start mult 2x3, cancel in the 2nd busy cycle -> busy=0 at that edge, HI=5, LO=6 retained.

Source files
------------

// File: rtl/execute_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_mdu_pkg
// Description : Shared definitions for the Execute-stage multiply/divide
//               unit. Holds the 4-bit MD op codes, which the decode
//               controller and hazard unit also use, and the default
//               busy-cycle counts.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package execute_mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_multicycle(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : execute_mdu_arith
// Description : Combinational result generator for the multiply/divide
//               unit. Produces the HI/LO pair for mult/multu (64-bit
//               product) and div/divu (remainder/quotient) and flags a
//               zero divisor.
// Ports       : op          - MD op code (only 1..4 are meaningful)
//               a, b        - operands rs / rt
//               hi, lo      - result halves destined for HI/LO
//               div_by_zero - divide op with b == 0
// Revision    : 1.0 - initial release
// ============================================================================
module execute_mdu_arith
    import execute_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_is_div = (op == MD_DIV)  || (op == MD_DIVU);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    assign w_a_ext = {{32{w_signed & a[31]}}, a};
    assign w_b_ext = {{32{w_signed & b[31]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed division is done on magnitudes so truncation toward zero and
    // the remainder sign are explicit. 0x80000000 / -1 falls out naturally:
    // its magnitude 0x80000000 divided by 1, sign unchanged.
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
    // Substitute divisor 1 on zero so the divider never sees 0; the result
    // is discarded by the caller via div_by_zero.
    assign w_b_safe = (b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign div_by_zero = w_is_div && (b == 32'd0);
    assign hi          = w_is_div ? w_r : w_prod[63:32];
    assign lo          = w_is_div ? w_q : w_prod[31:0];

endmodule
`default_nettype wire

// File: rtl/execute_mdu.sv
`default_nettype none
// ============================================================================
// Module      : execute_mdu
// Description : Multi-cycle multiply/divide unit of the Execute stage.
//               Owns HI/LO, the pending-result registers, the busy-cycle
//               counter and busy. Results are computed at issue and held
//               until the last busy cycle, then committed to HI/LO.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               start        - issue pulse for mult/multu/div/divu
//               op           - MD op code (execute_mdu_pkg::MD_*)
//               A, B         - operands rs / rt
//               busy         - operation in flight
//               HI, LO       - architectural HI/LO
//               MDOut        - HI on mfhi, LO on mflo, else 0
//               cancel       - (MDU_CANCEL_EN only) abort/suppress
// Config      : `define MDU_CANCEL_EN adds the cancel input.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_mdu
    import execute_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_valid;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_div_by_zero;
    logic               w_is_mult;
    logic               w_kill;

    execute_mdu_arith u_arith (
        .op          (op),
        .a           (A),
        .b           (B),
        .hi          (w_res_hi),
        .lo          (w_res_lo),
        .div_by_zero (w_div_by_zero)
    );

    assign w_is_mult = (op == MD_MULT) || (op == MD_MULTU);

`ifdef MDU_CANCEL_EN
    assign w_kill = cancel;
`else
    assign w_kill = 1'b0;
`endif

    // busy is the state: low = IDLE, high = RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_pend_hi    <= '0;
            r_pend_lo    <= '0;
            r_pend_valid <= 1'b0;
        end else if (r_busy) begin
            // start and mthi/mtlo are deliberately ignored while running.
            if (w_kill) begin
                r_busy       <= 1'b0;
                r_cnt        <= '0;
                r_pend_valid <= 1'b0;
            end else if (r_cnt == '0) begin
                r_busy       <= 1'b0;
                r_pend_valid <= 1'b0;
                if (r_pend_valid) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end else if (!w_kill) begin
            if (start && is_md_multicycle(op)) begin
                r_busy       <= 1'b1;
                r_cnt        <= w_is_mult ? c_mult_load : c_div_load;
                r_pend_hi    <= w_res_hi;
                r_pend_lo    <= w_res_lo;
                // A zero divisor still occupies the unit but leaves HI/LO.
                r_pend_valid <= !w_div_by_zero;
            end else if (op == MD_MTHI) begin
                r_hi <= A;
            end else if (op == MD_MTLO) begin
                r_lo <= A;
            end
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (op == MD_MFHI) begin
            MDOut = r_hi;
        end else if (op == MD_MFLO) begin
            MDOut = r_lo;
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire
